// File: rtl/cc3000_spi_write_seq.sv
// cc3000_spi_write_seq: frames and shifts CC3000 SPI write packets (mode 1, MSB first).
// Define CC3000_FIRST_WRITE_DELAY_EN to insert the first-write gap before header byte 5.
module cc3000_spi_write_seq #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned IRQ_TIMEOUT = 65535,
    parameter int unsigned CS_SETUP    = 8,
    parameter int unsigned FIRST_DELAY = 5000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [15:0] LEN,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    input  logic [7:0]  TX_DATA,
    input  logic        TX_VALID,
    output logic        TX_READY,
    input  logic        SPI_IRQ_N,
    output logic        SPI_CS_N,
    output logic        SPI_SCLK,
    output logic        SPI_MOSI
);
    localparam int unsigned M1 = (IRQ_TIMEOUT > FIRST_DELAY) ? IRQ_TIMEOUT : FIRST_DELAY;
    localparam int unsigned M2 = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
    localparam int unsigned CW = $clog2(((M1 > M2) ? M1 : M2) + 1);

    typedef enum logic [2:0] {IDLE, WAIT_IRQ, SETUP, HEADER, PAYLOAD, PAD, HOLD, DELAY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] div;
    logic [2:0]    bit_cnt;
    logic [7:0]    sh;
    logic          act;
    logic [2:0]    hdr_idx;
    logic [15:0]   l_q;
    logic [15:0]   rem;
    logic          pad_q;
    logic          irq_m;
    logic          irq_s;
    logic          byte_end;
    logic          tx_fire;
    logic          gap;
    logic          ld;
    logic [7:0]    ld_byte;
    logic [7:0]    hdr_nxt;
`ifdef CC3000_FIRST_WRITE_DELAY_EN
    logic          first_q;
`endif

    // byte_end marks the end of the last bit's low phase; a load in that cycle keeps SCLK gapless
    always_comb begin
        byte_end = act && div == CW'(CLK_DIV - 1) && !SPI_SCLK && bit_cnt == 3'd0;
        TX_READY = state == PAYLOAD && rem != 16'd0 && (!act || byte_end);
        tx_fire = TX_READY && TX_VALID;
`ifdef CC3000_FIRST_WRITE_DELAY_EN
        gap = first_q && hdr_idx == 3'd4;
`else
        gap = 1'b0;
`endif
        hdr_nxt = hdr_idx == 3'd1 ? l_q[15:8] : hdr_idx == 3'd2 ? l_q[7:0] : 8'h00;
        ld = (state == SETUP && cnt == CW'(CS_SETUP - 1))
            || (state == HEADER && byte_end && hdr_idx != 3'd5 && !gap)
            || (state == DELAY && cnt == CW'(FIRST_DELAY - 1))
            || tx_fire
            || (state == PAYLOAD && rem == 16'd0 && byte_end && pad_q);
        ld_byte = state == SETUP ? 8'h01 : state == HEADER ? hdr_nxt : tx_fire ? TX_DATA : 8'h00;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            cnt      <= '0;
            div      <= '0;
            bit_cnt  <= '0;
            sh       <= '0;
            act      <= 1'b0;
            hdr_idx  <= '0;
            l_q      <= '0;
            rem      <= '0;
            pad_q    <= 1'b0;
            irq_m    <= 1'b1;
            irq_s    <= 1'b1;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            SPI_CS_N <= 1'b1;
            SPI_SCLK <= 1'b0;
            SPI_MOSI <= 1'b0;
`ifdef CC3000_FIRST_WRITE_DELAY_EN
            first_q  <= 1'b1;
`endif
        end else begin
            irq_m <= SPI_IRQ_N;
            irq_s <= irq_m;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
            if (ld) begin
                act      <= 1'b1;
                SPI_SCLK <= 1'b1;
                SPI_MOSI <= ld_byte[7];
                sh       <= {ld_byte[6:0], 1'b0};
                bit_cnt  <= 3'd7;
                div      <= '0;
            end else if (act) begin
                if (div == CW'(CLK_DIV - 1)) begin
                    div <= '0;
                    if (SPI_SCLK) begin
                        SPI_SCLK <= 1'b0;
                    end else if (bit_cnt != 3'd0) begin
                        SPI_SCLK <= 1'b1;
                        SPI_MOSI <= sh[7];
                        sh       <= {sh[6:0], 1'b0};
                        bit_cnt  <= bit_cnt - 3'd1;
                    end else begin
                        act <= 1'b0;
                    end
                end else begin
                    div <= div + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    BUSY <= 1'b0;
                    if (START && !BUSY) begin
                        if (LEN == 16'd0) begin
                            ERR <= 1'b1;
                        end else begin
                            l_q      <= LEN + {15'd0, ~LEN[0]};
                            rem      <= LEN;
                            pad_q    <= ~LEN[0];
                            SPI_CS_N <= 1'b0;
                            BUSY     <= 1'b1;
                            cnt      <= '0;
                            state    <= WAIT_IRQ;
                        end
                    end
                end
                WAIT_IRQ: begin
                    if (!irq_s) begin
                        cnt   <= '0;
                        state <= SETUP;
                    end else if (cnt == CW'(IRQ_TIMEOUT - 1)) begin
                        SPI_CS_N <= 1'b1;
                        ERR      <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SETUP: begin
                    cnt <= cnt + 1'b1;
                    if (ld) begin
                        hdr_idx <= 3'd1;
                        state   <= HEADER;
                    end
                end
                HEADER: begin
                    if (ld) begin
                        hdr_idx <= hdr_idx + 3'd1;
                    end else if (byte_end) begin
                        cnt   <= '0;
                        state <= hdr_idx == 3'd5 ? PAYLOAD : DELAY;
                    end
                end
                DELAY: begin
                    cnt <= cnt + 1'b1;
                    if (ld) begin
                        hdr_idx <= 3'd5;
                        state   <= HEADER;
                    end
                end
                PAYLOAD: begin
                    if (tx_fire) rem <= rem - 16'd1;
                    if (rem == 16'd0 && byte_end) begin
                        cnt   <= '0;
                        state <= pad_q ? PAD : HOLD;
                    end
                end
                PAD: begin
                    if (byte_end) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == CW'(CLK_DIV - 1)) begin
                        SPI_CS_N <= 1'b1;
                        DONE     <= 1'b1;
                        state    <= IDLE;
`ifdef CC3000_FIRST_WRITE_DELAY_EN
                        first_q  <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cc3000_spi_write_seq.sv
// tb_cc3000_spi_write_seq: scoreboard bench; the monitor thread decodes MOSI bytes and DONE/ERR events.
module tb_cc3000_spi_write_seq;
`ifdef CC3000_FIRST_WRITE_DELAY_EN
    localparam int GAP1 = 200;
`else
    localparam int GAP1 = 0;
`endif
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic        busy, done, err;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic        irq_n;
    logic        cs_n, sclk, mosi;

    always #5 clk = ~clk;

    cc3000_spi_write_seq #(.CLK_DIV(2), .IRQ_TIMEOUT(100), .CS_SETUP(8), .FIRST_DELAY(200)) dut (
        .CLK(clk), .RESET(rst), .START(start), .LEN(len), .BUSY(busy), .DONE(done), .ERR(err),
        .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready), .SPI_IRQ_N(irq_n),
        .SPI_CS_N(cs_n), .SPI_SCLK(sclk), .SPI_MOSI(mosi)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    int         evt_q[$];
    int         rise_t[$];
    int         cyc = 0;
    int         rises = 0;
    int         nbits = 0;
    logic [7:0] shreg = 8'h00;
    logic       sclk_prev = 1'b0;
    logic [7:0] pl[8];
    logic [7:0] ex[12];

    function automatic void chk(string name, int got, int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
        end
    endfunction

    // event codes: 1 = DONE, 2 = ERR
    task automatic monitor();
        int code;
        forever begin
            @(negedge clk);
            cyc++;
            if (sclk && !sclk_prev) begin
                rises++;
                rise_t.push_back(cyc);
                shreg = {shreg[6:0], mosi};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL mosi_extra_byte: got 0x%0h, no byte expected", shreg);
                    end else begin
                        chk("mosi_byte", shreg, exp_q.pop_front());
                    end
                    chk("cs_low_during_byte", cs_n, 0);
                end
            end
            sclk_prev = sclk;
            if (done || err) begin
                code = (done ? 1 : 0) + (err ? 2 : 0);
                if (evt_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got code %0d, none expected", code);
                end else begin
                    chk("event_kind", code, evt_q.pop_front());
                end
                if (done) begin
                    chk("bytes_left_at_done", exp_q.size(), 0);
                    chk("partial_bits_at_done", nbits, 0);
                end
            end
        end
    endtask

    task automatic pulse_start(input logic [15:0] l);
        @(negedge clk);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_pkt(input logic [15:0] l, input int npl, input int nex, input int irq_dly,
                           input bit stall, input int gap, input int exp_rises, input int pay_span);
        int  r0;
        int  k;
        bit  ok;
        for (int i = 0; i < nex; i++) exp_q.push_back(ex[i]);
        evt_q.push_back(1);
        rise_t.delete();
        r0 = rises;
        if (irq_dly == 0) irq_n = 1'b0;
        pulse_start(l);
        chk("cs_low_after_start", cs_n, 0);
        chk("busy_after_start", busy, 1);
        if (irq_dly > 0) begin
            repeat (irq_dly) @(negedge clk);
            irq_n = 1'b0;
        end
        if (stall) begin
            k = 0;
            while (!tx_ready && k < 2000) begin @(negedge clk); k++; end
            chk("ready_before_stall", tx_ready, 1);
            ok = 1'b1;
            repeat (50) begin
                @(negedge clk);
                if (sclk || cs_n) ok = 1'b0;
            end
            chk("stall_sclk_low_cs_low", ok, 1);
        end
        for (int i = 0; i < npl; i++) begin
            tx_data  = pl[i];
            tx_valid = 1'b1;
            k = 0;
            while (!tx_ready && k < 2000) begin @(negedge clk); k++; end
            if (k >= 2000) chk("tx_ready_timeout", 0, 1);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        k = 0;
        while (busy && k < 5000) begin @(negedge clk); k++; end
        chk("busy_low_after_pkt", busy, 0);
        chk("cs_high_after_pkt", cs_n, 1);
        chk("sclk_rises", rises - r0, exp_rises);
        if (rise_t.size() >= 40) chk("header_span", rise_t[39] - rise_t[0], 156 + gap);
        else chk("header_rises", rise_t.size(), 40);
        if (pay_span >= 0 && rise_t.size() >= 64) chk("payload_span", rise_t[63] - rise_t[40], pay_span);
        irq_n = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = 16'd0; tx_data = 8'h00; tx_valid = 1'b0; irq_n = 1'b1;
        fork
            monitor();
            begin
                int r0;
                int k;
                repeat (3) @(negedge clk);
                chk("rst_cs_n", cs_n, 1);
                chk("rst_sclk", sclk, 0);
                chk("rst_mosi", mosi, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done_err", {done, err}, 0);
                chk("rst_tx_ready", tx_ready, 0);
                rst = 1'b0;
                repeat (2) @(negedge clk);

                pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
                ex[0] = 8'h01; ex[1] = 8'h00; ex[2] = 8'h03; ex[3] = 8'h00; ex[4] = 8'h00;
                ex[5] = 8'hA1; ex[6] = 8'hB2; ex[7] = 8'hC3;
                run_pkt(16'd3, 3, 8, 10, 1'b0, GAP1, 64, 92);

                pl[0] = 8'h55; pl[1] = 8'hAA;
                ex[5] = 8'h55; ex[6] = 8'hAA; ex[7] = 8'h00;
                run_pkt(16'd2, 2, 8, 10, 1'b0, 0, 64, 92);

                evt_q.push_back(2);
                r0 = rises;
                pulse_start(16'd5);
                chk("timeout_cs_low", cs_n, 0);
                k = 0;
                while (!err && k < 300) begin @(negedge clk); k++; end
                chk("timeout_cycles", k, 100);
                chk("timeout_cs_high", cs_n, 1);
                chk("timeout_busy_in_err_cycle", busy, 1);
                @(negedge clk);
                chk("timeout_busy_after", busy, 0);
                chk("timeout_no_sclk", rises - r0, 0);

                evt_q.push_back(2);
                pulse_start(16'd0);
                chk("len0_err", err, 1);
                chk("len0_cs_n", cs_n, 1);
                chk("len0_busy", busy, 0);
                @(negedge clk);
                chk("len0_err_one_cycle", err, 0);

                pl[0] = 8'h5A;
                ex[2] = 8'h01; ex[5] = 8'h5A;
                run_pkt(16'd1, 1, 6, 0, 1'b1, 0, 48, -1);

                ex[2] = 8'h05; ex[5] = 8'h10;
                for (int i = 0; i < 6; i++) exp_q.push_back(ex[i]);
                r0 = rises;
                irq_n = 1'b0;
                pulse_start(16'd4);
                tx_data  = 8'h10;
                tx_valid = 1'b1;
                k = 0;
                while (!tx_ready && k < 2000) begin @(negedge clk); k++; end
                @(negedge clk);
                tx_valid = 1'b0;
                k = 0;
                while (rises - r0 < 44 && k < 2000) begin @(negedge clk); k++; end
                chk("abort_reached_payload", rises - r0, 44);
                rst = 1'b1;
                @(negedge clk);
                chk("abort_cs_high", cs_n, 1);
                chk("abort_sclk_low", sclk, 0);
                chk("abort_busy_low", busy, 0);
                chk("abort_no_done", done, 0);
                rst = 1'b0;
                irq_n = 1'b1;
                exp_q.delete();
                nbits = 0;
                repeat (20) @(negedge clk);

                pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
                ex[2] = 8'h03; ex[5] = 8'h11; ex[6] = 8'h22; ex[7] = 8'h33;
                run_pkt(16'd3, 3, 8, 10, 1'b0, GAP1, 64, 92);

                repeat (10) @(negedge clk);
                chk("events_pending", evt_q.size(), 0);
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        join_any
    end
endmodule
